// File: rtl/conv3x3_pass_scheduler.sv
// Pass scheduler for the four-lane 3x3 convolution wrapper: runs N_PASS passes over one map,
// drains the wrapper between passes and tags every wrapper result with row/col/channel base.
module conv3x3_pass_scheduler #(
    parameter int unsigned IMG_W  = 28,
    parameter int unsigned IMG_H  = 28,
    parameter int unsigned LAT    = 2,
    parameter int unsigned N_PASS = 4,
    parameter int unsigned CNTW   = $clog2((IMG_W - 2) * (IMG_H - 2) + 1)
) (
    input  logic            iClk,
    input  logic            iRsn,
    input  logic            iStart,
    input  logic            iWinAvail,
    output logic            oWinPop,
    output logic            oInValid,
    output logic            oMapDone,
    output logic            oRewind,
    input  logic [3:0]      iValid4,
    output logic            oOutWe,
    output logic [CNTW-1:0] oOutRow,
    output logic [CNTW-1:0] oOutCol,
    output logic [3:0]      oOcBase,
    output logic [1:0]      oPhase,
    output logic            oBusy,
    output logic            oDone,
    output logic            oErr
);

    localparam int unsigned NWIN = (IMG_W - 2) * (IMG_H - 2);
    localparam logic [CNTW-1:0] LastWin = CNTW'(NWIN - 1);
    localparam logic [CNTW-1:0] NWinC = CNTW'(NWIN);
    localparam logic [CNTW-1:0] LastCol = CNTW'(IMG_W - 3);
    localparam logic [1:0] LastPhase = 2'(N_PASS - 1);

    if (IMG_W < 3 || IMG_H < 3 || N_PASS == 0 || N_PASS > 4 || LAT > 1024) begin : g_bad_param
        $error("conv3x3_pass_scheduler: unsupported parameter set");
    end

    typedef enum logic [2:0] {StIdle, StScan, StDrain, StMapDone, StFin} state_e;

    state_e          state_q, state_d;
    logic [CNTW-1:0] win_cnt_q, win_cnt_d;
    logic [CNTW-1:0] out_cnt_q, out_cnt_d;
    logic [CNTW-1:0] out_row_q, out_row_d;
    logic [CNTW-1:0] out_col_q, out_col_d;
    logic [1:0]      phase_q, phase_d;
    logic            err_q, err_d;
    logic            tag_we_q, tag_we_d;
    logic [CNTW-1:0] tag_row_q, tag_row_d;
    logic [CNTW-1:0] tag_col_q, tag_col_d;
    logic [3:0]      oc_base_q, oc_base_d;
    logic            pop;
    logic            vld;
    logic            proto_bad;

    assign pop = (state_q == StScan) && iWinAvail;
    assign vld = iValid4[0];
    assign proto_bad = (iValid4 != 4'b0000 && iValid4 != 4'b1111)
                    || (state_q == StIdle && iValid4 != 4'b0000)
                    || (vld && out_cnt_q == NWinC);

    always_comb begin
        state_d   = state_q;
        win_cnt_d = win_cnt_q;
        out_cnt_d = out_cnt_q;
        out_row_d = out_row_q;
        out_col_d = out_col_q;
        phase_d   = phase_q;
        err_d     = err_q;
        tag_we_d  = 1'b0;
        tag_row_d = tag_row_q;
        tag_col_d = tag_col_q;
        oc_base_d = oc_base_q;

        // Tagging runs in every state so late results of a pass are never lost.
        if (vld) begin
            tag_we_d  = 1'b1;
            tag_row_d = out_row_q;
            tag_col_d = out_col_q;
            oc_base_d = {phase_q, 2'b00};
            if (out_cnt_q != NWinC) begin
                out_cnt_d = out_cnt_q + CNTW'(1);
            end
            if (out_col_q == LastCol) begin
                out_col_d = '0;
                out_row_d = out_row_q + CNTW'(1);
            end else begin
                out_col_d = out_col_q + CNTW'(1);
            end
        end

        unique case (state_q)
            StIdle: begin
                if (iStart) begin
                    state_d   = StScan;
                    win_cnt_d = '0;
                    out_cnt_d = '0;
                    out_row_d = '0;
                    out_col_d = '0;
                    err_d     = 1'b0;
                end
            end
            StScan: begin
                if (pop) begin
                    win_cnt_d = win_cnt_q + CNTW'(1);
                    if (win_cnt_q == LastWin) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (out_cnt_d == NWinC) begin
                    state_d = StMapDone;
                end
            end
            StMapDone: begin
                win_cnt_d = '0;
                out_cnt_d = '0;
                out_row_d = '0;
                out_col_d = '0;
                phase_d   = (phase_q == LastPhase) ? 2'd0 : phase_q + 2'd1;
                state_d   = (phase_q == LastPhase) ? StFin : StScan;
            end
            StFin: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (proto_bad) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRsn) begin
            state_q   <= StIdle;
            win_cnt_q <= '0;
            out_cnt_q <= '0;
            out_row_q <= '0;
            out_col_q <= '0;
            phase_q   <= '0;
            err_q     <= 1'b0;
            tag_we_q  <= 1'b0;
            tag_row_q <= '0;
            tag_col_q <= '0;
            oc_base_q <= '0;
        end else begin
            state_q   <= state_d;
            win_cnt_q <= win_cnt_d;
            out_cnt_q <= out_cnt_d;
            out_row_q <= out_row_d;
            out_col_q <= out_col_d;
            phase_q   <= phase_d;
            err_q     <= err_d;
            tag_we_q  <= tag_we_d;
            tag_row_q <= tag_row_d;
            tag_col_q <= tag_col_d;
            oc_base_q <= oc_base_d;
        end
    end

    assign oWinPop  = pop;
    assign oInValid = pop;
    assign oMapDone = (state_q == StMapDone);
    assign oRewind  = (state_q == StMapDone) && (phase_q != LastPhase);
    assign oDone    = (state_q == StFin);
    assign oBusy    = (state_q != StIdle);
    assign oErr     = err_q;
    assign oPhase   = phase_q;
    assign oOutWe   = tag_we_q;
    assign oOutRow  = tag_row_q;
    assign oOutCol  = tag_col_q;
    assign oOcBase  = oc_base_q;

endmodule
